snes_multi_pad_reader: RTL and testbench
========================================

// Module: snes_multi_pad_reader
// PURPOSE
//  Polls NUM_PADS NES/SNES controllers over a shared latch/clock pair, one serial Data line per pad.
//  Generates protocol timing from the system clock and decodes active-low serial data into active-high buttons.
//  Publishes per-pad button vectors, new-press flags and connection status once per poll frame.
//  Feeds the game/VGA logic, which samples all outputs on the cycle Readable pulses.
// PARAMETERS
//  NUM_PADS    2     number of controller ports (1..4)
//  TICK_CYCLES 300   Clock cycles per protocol tick (6 us at 50 MHz); >= 2
//  POLL_TICKS  2778  ticks per poll frame (~60 Hz); must be >= 35
// PORTS
//  Clock         in   1            system clock, all logic on posedge
//  Reset         in   1            asynchronous, active-high reset
//  Mode          in   1            0 = NES (8 bits/frame), 1 = SNES (16 bits/frame)
//  Data          in   NUM_PADS     serial data per pad, active low; board pulls unused lines low
//  Strobe_Latch  out  1            latch pulse to all pads
//  Shift_Clock   out  1            shift clock to all pads, idles high
//  Buttons       out  16*NUM_PADS  pad p at [16p+15:16p]; bit k = button k pressed (1)
//  Pressed       out  16*NUM_PADS  bit set = button went 0->1 in the latest frame
//  Connected     out  NUM_PADS     pad present in the latest frame
//  Readable      out  1            1-cycle pulse: Buttons/Pressed/Connected just updated
// BEHAVIOUR
//  Reset (async): FSM=IDLE, tick/poll/bit counters 0, Strobe_Latch=0, Shift_Clock=1, Buttons=0,
//   Pressed=0, Connected=0, Readable=0, shift regs 0. Reset mid-frame aborts with no Readable.
//  Tick: prescaler counts 0..TICK_CYCLES-1, tick strobe on the terminal count; all FSM phases are tick-aligned.
//  Poll counter counts ticks 0..POLL_TICKS-1, wraps; frame starts when it is 0 (first tick after Reset release).
//  FSM IDLE -> LATCH -> SHIFT -> DONE -> IDLE.
//   IDLE: on frame-start tick, capture Mode into mode_q, enter LATCH.
//   LATCH: Strobe_Latch=1 for exactly 2 ticks, Shift_Clock=1; then SHIFT, bit index k=0.
//   SHIFT: per bit, 2 ticks: phase A Shift_Clock=0, phase B Shift_Clock=1.
//    On the Clock cycle entering phase A, sample raw[p][k] = Data[p] for every pad.
//    After phase B of bit N-1 (N = 8 if mode_q=0 else 16) -> DONE.
//   DONE (1 Clock cycle): update outputs, Readable=1, -> IDLE. Readable is 0 in all other cycles.
//  Mode changes mid-frame are ignored until the next IDLE->LATCH capture.
//  Decode per pad p (at DONE): btn = ~raw; NES: bits 15:8 forced 0.
//   Order: NES  0 A,1 B,2 Select,3 Start,4 Up,5 Down,6 Left,7 Right.
//          SNES 0 B,1 Y,2 Select,3 Start,4 Up,5 Down,6 Left,7 Right,8 A,9 X,10 L,11 R, 15:12 ID.
//   Connected[p]: SNES = raw[15:12]==4'b1111; NES = raw[7:0]!=8'h00.
//   Bits 15:12 of Buttons are always 0 (ID bits not exported).
//   If !Connected[p]: Buttons/Pressed for pad p written as 0.
//   Pressed = new Buttons & ~previous Buttons (per bit); all outputs hold until next DONE.
//  Latency: Readable asserts 1 Clock after the final bit-(N-1) phase B tick.
//  Frame timing: Readable pulses once per POLL_TICKS*TICK_CYCLES Clocks in steady state.
// TESTING (bench uses TICK_CYCLES=2, POLL_TICKS=40, NUM_PADS=2)
//  1 Reset mid-SHIFT -> all outputs immediately at reset values, no Readable; after release
//    Strobe_Latch high for exactly 4 Clocks starting at first tick.
//  2 NES, pad0 raw bits 0..7 = 1,1,1,1,0,1,1,1 -> Buttons[15:0]=16'h0010, Connected[0]=1,
//    Pressed[15:0]=16'h0010 frame 1, 16'h0000 frame 2 with same stimulus.
//  3 SNES, pad1 Data held 0 -> Connected[1]=0, Buttons[31:16]=0, Pressed[31:16]=0.
//  4 SNES, pad0 raw all 1 except bit 8 -> Buttons[15:0]=16'h0100, Connected[0]=1.
//  5 Mode 0->1 during SHIFT -> current frame gives 8 Shift_Clock falls, next frame 16.
//  6 Steady state -> Readable period = 80 Clocks; Shift_Clock never low while Strobe_Latch=1.

Source files
------------

// File: rtl/snes_multi_pad_reader_if.sv
// Pad-side bundle for snes_multi_pad_reader. The reader connects through the master
// modport. The pads and the game logic connect through the slave modport.
interface snes_multi_pad_reader_if #(
    parameter int NUM_PADS = 2
);
    logic                    Mode;
    logic [NUM_PADS-1:0]     Data;
    logic                    Strobe_Latch;
    logic                    Shift_Clock;
    logic [16*NUM_PADS-1:0]  Buttons;
    logic [16*NUM_PADS-1:0]  Pressed;
    logic [NUM_PADS-1:0]     Connected;
    logic                    Readable;

    modport master (
        input  Mode, Data,
        output Strobe_Latch, Shift_Clock, Buttons, Pressed, Connected, Readable
    );

    modport slave (
        output Mode, Data,
        input  Strobe_Latch, Shift_Clock, Buttons, Pressed, Connected, Readable
    );
endinterface

// File: rtl/snes_multi_pad_reader.sv
// Polls NES/SNES pads over a shared latch/clock pair and decodes their active-low serial data.
// The button, new-press and connection outputs are published once per poll frame, marked by Readable.
module snes_multi_pad_reader #(
    parameter int NUM_PADS    = 2,
    parameter int TICK_CYCLES = 300,
    parameter int POLL_TICKS  = 2778
) (
    input  logic                    Clock,
    input  logic                    Reset,
    snes_multi_pad_reader_if.master bus
);
    localparam int TW = $clog2(TICK_CYCLES);
    localparam int PW = $clog2(POLL_TICKS);
    localparam int BW = 16 * NUM_PADS;

    typedef enum logic [1:0] {IDLE, LATCH, SHIFT, DONE} state_t;

    state_t             state;
    logic [TW-1:0]      tick_cnt;
    logic [PW-1:0]      poll_cnt;
    logic               tick;
    logic               phase;
    logic [3:0]         bit_idx;
    logic               mode_q;
    logic               strobe_q;
    logic               sclk_q;
    logic               readable_q;
    logic [BW-1:0]      buttons_q;
    logic [BW-1:0]      pressed_q;
    logic [NUM_PADS-1:0] connected_q;
    logic [15:0]        raw [NUM_PADS];

    logic [BW-1:0]       next_buttons;
    logic [BW-1:0]       next_pressed;
    logic [NUM_PADS-1:0] next_connected;
    logic [3:0]          last_bit;
    logic [3:0]          next_bit;

    // SNES pads report ID 4'b1111 in bits 15:12. An absent pad reads all zeros because of the pull-downs.
    function automatic logic pad_connected(input logic [15:0] r, input logic snes);
        return snes ? (r[15:12] == 4'hF) : (r[7:0] != 8'h00);
    endfunction

    function automatic logic [15:0] decode_buttons(input logic [15:0] r, input logic snes);
        logic [15:0] btn;
        btn = ~r;
        btn[15:12] = 4'h0;
        if (!snes) btn[11:8] = 4'h0;
        return btn;
    endfunction

    assign tick     = (tick_cnt == TW'(TICK_CYCLES - 1));
    assign last_bit = mode_q ? 4'd15 : 4'd7;
    assign next_bit = bit_idx + 4'd1;

    always_comb begin
        next_buttons   = '0;
        next_pressed   = '0;
        next_connected = '0;
        for (int p = 0; p < NUM_PADS; p++) begin
            next_connected[p] = pad_connected(raw[p], mode_q);
            if (next_connected[p])
                next_buttons[16*p +: 16] = decode_buttons(raw[p], mode_q);
            next_pressed[16*p +: 16] = next_buttons[16*p +: 16] & ~buttons_q[16*p +: 16];
        end
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            tick_cnt <= '0;
            poll_cnt <= '0;
        end else begin
            tick_cnt <= tick ? '0 : tick_cnt + TW'(1);
            if (tick)
                poll_cnt <= (poll_cnt == PW'(POLL_TICKS - 1)) ? '0 : poll_cnt + PW'(1);
        end
    end

    // Every transition except DONE->IDLE happens on a tick. Each pad's Data is sampled on the edge where Shift_Clock falls.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state       <= IDLE;
            phase       <= 1'b0;
            bit_idx     <= '0;
            mode_q      <= 1'b0;
            strobe_q    <= 1'b0;
            sclk_q      <= 1'b1;
            readable_q  <= 1'b0;
            buttons_q   <= '0;
            pressed_q   <= '0;
            connected_q <= '0;
            for (int p = 0; p < NUM_PADS; p++) raw[p] <= '0;
        end else begin
            readable_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (tick && poll_cnt == '0) begin
                        mode_q   <= bus.Mode;
                        strobe_q <= 1'b1;
                        sclk_q   <= 1'b1;
                        phase    <= 1'b0;
                        state    <= LATCH;
                    end
                end
                LATCH: begin
                    if (tick) begin
                        if (!phase) begin
                            phase <= 1'b1;
                        end else begin
                            strobe_q <= 1'b0;
                            sclk_q   <= 1'b0;
                            phase    <= 1'b0;
                            bit_idx  <= '0;
                            for (int p = 0; p < NUM_PADS; p++) raw[p][0] <= bus.Data[p];
                            state    <= SHIFT;
                        end
                    end
                end
                SHIFT: begin
                    if (tick) begin
                        if (!phase) begin
                            sclk_q <= 1'b1;
                            phase  <= 1'b1;
                        end else if (bit_idx == last_bit) begin
                            buttons_q   <= next_buttons;
                            pressed_q   <= next_pressed;
                            connected_q <= next_connected;
                            readable_q  <= 1'b1;
                            state       <= DONE;
                        end else begin
                            bit_idx <= next_bit;
                            sclk_q  <= 1'b0;
                            phase   <= 1'b0;
                            for (int p = 0; p < NUM_PADS; p++) raw[p][next_bit] <= bus.Data[p];
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.Strobe_Latch = strobe_q;
    assign bus.Shift_Clock  = sclk_q;
    assign bus.Buttons      = buttons_q;
    assign bus.Pressed      = pressed_q;
    assign bus.Connected    = connected_q;
    assign bus.Readable     = readable_q;
endmodule

// File: tb/tb_snes_multi_pad_reader.sv
// Bench for snes_multi_pad_reader. Pad shift registers are modelled behaviourally.
// Each published frame is compared against a decode model built from the pad reports.
module tb_snes_multi_pad_reader;
    localparam int NP = 2;
    localparam int TC = 2;
    localparam int PT = 40;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    snes_multi_pad_reader_if #(.NUM_PADS(NP)) bus();

    snes_multi_pad_reader #(.NUM_PADS(NP), .TICK_CYCLES(TC), .POLL_TICKS(PT)) dut (
        .Clock (clk),
        .Reset (rst),
        .bus   (bus)
    );

    logic          mode_r = 1'b0;
    logic [15:0]   rep [NP];
    logic [NP-1:0] data_w;
    logic [3:0]    pad_idx = 4'd0;
    logic          sclk_prev = 1'b1;
    int            falls = 0;
    int            viol = 0;
    int            checks = 0;
    int            errors = 0;

    logic [15:0]   prev [NP];
    logic [31:0]   e_btn, e_prs;
    logic [NP-1:0] e_con;

    // Each pad model drives bit 0 while latched and advances one bit on each rising Shift_Clock.
    always_comb begin
        data_w = '0;
        for (int p = 0; p < NP; p++) data_w[p] = rep[p][pad_idx];
    end
    assign bus.Mode = mode_r;
    assign bus.Data = data_w;

    always @(negedge clk) begin
        if (bus.Strobe_Latch) pad_idx <= 4'd0;
        else if (!sclk_prev && bus.Shift_Clock && pad_idx != 4'd15) pad_idx <= pad_idx + 4'd1;
        if (sclk_prev && !bus.Shift_Clock) falls <= falls + 1;
        if (bus.Strobe_Latch && !bus.Shift_Clock) viol <= viol + 1;
        sclk_prev <= bus.Shift_Clock;
    end

    task automatic model_frame(input logic mode);
        logic        conn;
        logic [15:0] b;
        for (int p = 0; p < NP; p++) begin
            conn = mode ? (rep[p][15:12] == 4'hF) : (rep[p][7:0] != 8'h00);
            b = ~rep[p] & (mode ? 16'h0FFF : 16'h00FF);
            if (!conn) b = 16'h0000;
            e_con[p] = conn;
            e_btn[16*p +: 16] = b;
            e_prs[16*p +: 16] = b & ~prev[p];
            prev[p] = b;
        end
    endtask

    task automatic wait_readable(output bit ok, output int cyc);
        ok = 1'b0;
        cyc = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            cyc++;
            if (bus.Readable === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic set_stim(input logic m, input logic [15:0] r0, input logic [15:0] r1);
        mode_r = m;
        rep[0] = r0;
        rep[1] = r1;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++;
        if ({bus.Strobe_Latch, bus.Shift_Clock, bus.Readable, bus.Connected, bus.Buttons, bus.Pressed} !== {3'b010, 66'd0}) begin
            errors++;
            $display("FAIL reset_values got %b%b%b %b %h %h want 010 00 0 0", bus.Strobe_Latch, bus.Shift_Clock,
                     bus.Readable, bus.Connected, bus.Buttons, bus.Pressed);
        end
        for (int p = 0; p < NP; p++) prev[p] = 16'h0;
        set_stim(1'b0, 16'h00EF, 16'h0000);
        rst = 1'b0;
    endtask

    task automatic test_nes_press();
        bit ok;
        int cyc;
        for (int f = 0; f < 2; f++) begin
            wait_readable(ok, cyc);
            checks++;
            if (!ok) begin errors++; $display("FAIL nes_timeout frame %0d no Readable", f); end
            model_frame(1'b0);
            checks++;
            if (bus.Buttons[15:0] !== 16'h0010 || bus.Connected[0] !== 1'b1) begin
                errors++;
                $display("FAIL nes_btn frame %0d got %h con %b want 0010 con 1", f, bus.Buttons[15:0], bus.Connected[0]);
            end
            checks++;
            if (bus.Pressed[15:0] !== ((f == 0) ? 16'h0010 : 16'h0000)) begin
                errors++;
                $display("FAIL nes_pressed frame %0d got %h want %h", f, bus.Pressed[15:0], (f == 0) ? 16'h0010 : 16'h0000);
            end
            checks++;
            if ({bus.Connected, bus.Buttons, bus.Pressed} !== {e_con, e_btn, e_prs}) begin
                errors++;
                $display("FAIL nes_model frame %0d got %b %h %h want %b %h %h", f, bus.Connected, bus.Buttons,
                         bus.Pressed, e_con, e_btn, e_prs);
            end
        end
    endtask

    task automatic test_snes_disconnected();
        bit ok;
        int cyc;
        set_stim(1'b1, 16'hFFFF, 16'h0000);
        wait_readable(ok, cyc);
        model_frame(1'b1);
        checks++;
        if (!ok || bus.Connected[1] !== 1'b0 || bus.Buttons[31:16] !== 16'h0 || bus.Pressed[31:16] !== 16'h0) begin
            errors++;
            $display("FAIL snes_disc ok %b got con %b btn %h prs %h want con 0 btn 0000 prs 0000", ok, bus.Connected[1],
                     bus.Buttons[31:16], bus.Pressed[31:16]);
        end
        checks++;
        if ({bus.Connected, bus.Buttons, bus.Pressed} !== {e_con, e_btn, e_prs}) begin
            errors++;
            $display("FAIL snes_disc_model got %b %h %h want %b %h %h", bus.Connected, bus.Buttons, bus.Pressed,
                     e_con, e_btn, e_prs);
        end
    endtask

    task automatic test_snes_bit8();
        bit ok;
        int cyc;
        set_stim(1'b1, 16'hFEFF, 16'hFFFF);
        wait_readable(ok, cyc);
        model_frame(1'b1);
        checks++;
        if (!ok || bus.Buttons[15:0] !== 16'h0100 || bus.Connected !== 2'b11) begin
            errors++;
            $display("FAIL snes_bit8 ok %b got btn %h con %b want btn 0100 con 11", ok, bus.Buttons[15:0], bus.Connected);
        end
        checks++;
        if ({bus.Connected, bus.Buttons, bus.Pressed} !== {e_con, e_btn, e_prs}) begin
            errors++;
            $display("FAIL snes_bit8_model got %b %h %h want %b %h %h", bus.Connected, bus.Buttons, bus.Pressed,
                     e_con, e_btn, e_prs);
        end
    endtask

    task automatic test_random();
        bit ok;
        int cyc;
        logic        m;
        logic [15:0] r [NP];
        for (int f = 0; f < 10; f++) begin
            m = 1'($urandom_range(0, 1));
            for (int p = 0; p < NP; p++) begin
                r[p] = 16'($urandom);
                if ($urandom_range(0, 3) != 0) r[p][15:12] = 4'hF;
                if ($urandom_range(0, 4) == 0) r[p] = 16'h0000;
            end
            set_stim(m, r[0], r[1]);
            wait_readable(ok, cyc);
            model_frame(m);
            checks++;
            if (!ok || {bus.Connected, bus.Buttons, bus.Pressed} !== {e_con, e_btn, e_prs}) begin
                errors++;
                $display("FAIL random frame %0d mode %b ok %b got %b %h %h want %b %h %h", f, m, ok, bus.Connected,
                         bus.Buttons, bus.Pressed, e_con, e_btn, e_prs);
            end
        end
    endtask

    task automatic test_mode_switch();
        bit ok;
        int cyc;
        int f0;
        set_stim(1'b0, 16'hFF5A, 16'hFFC3);
        f0 = falls;
        for (int i = 0; i < 200 && falls == f0; i++) @(negedge clk);
        mode_r = 1'b1;
        wait_readable(ok, cyc);
        model_frame(1'b0);
        checks++;
        if (!ok || falls - f0 != 8) begin
            errors++;
            $display("FAIL mode_switch_nes ok %b got %0d falls want 8", ok, falls - f0);
        end
        checks++;
        if ({bus.Connected, bus.Buttons, bus.Pressed} !== {e_con, e_btn, e_prs}) begin
            errors++;
            $display("FAIL mode_switch_decode got %b %h %h want %b %h %h", bus.Connected, bus.Buttons, bus.Pressed,
                     e_con, e_btn, e_prs);
        end
        f0 = falls;
        wait_readable(ok, cyc);
        model_frame(1'b1);
        checks++;
        if (!ok || falls - f0 != 16) begin
            errors++;
            $display("FAIL mode_switch_snes ok %b got %0d falls want 16", ok, falls - f0);
        end
    endtask

    task automatic test_steady_timing();
        bit ok;
        int cyc;
        set_stim(1'b1, 16'hFFFE, 16'hFFFF);
        for (int f = 0; f < 2; f++) begin
            wait_readable(ok, cyc);
            model_frame(1'b1);
            checks++;
            if (!ok || cyc != PT * TC) begin
                errors++;
                $display("FAIL period frame %0d ok %b got %0d cycles want %0d", f, ok, cyc, PT * TC);
            end
        end
        checks++;
        if (viol != 0) begin
            errors++;
            $display("FAIL latch_overlap got %0d low-clock-while-latched samples want 0", viol);
        end
    endtask

    task automatic test_reset_mid_shift();
        bit ok;
        int cyc;
        int f0;
        int seen;
        int hi_cnt;
        int first_hi;
        set_stim(1'b1, 16'hF7FB, 16'hFFFF);
        f0 = falls;
        for (int i = 0; i < 200 && falls == f0; i++) @(negedge clk);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if ({bus.Strobe_Latch, bus.Shift_Clock, bus.Readable, bus.Connected, bus.Buttons, bus.Pressed} !== {3'b010, 66'd0}) begin
            errors++;
            $display("FAIL midreset_values got %b%b%b %b %h %h want 010 00 0 0", bus.Strobe_Latch, bus.Shift_Clock,
                     bus.Readable, bus.Connected, bus.Buttons, bus.Pressed);
        end
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (bus.Readable !== 1'b0) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL midreset_readable got %0d pulses want 0", seen);
        end
        for (int p = 0; p < NP; p++) prev[p] = 16'h0;
        rst = 1'b0;
        hi_cnt = 0;
        first_hi = -1;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            if (bus.Strobe_Latch === 1'b1) begin
                hi_cnt++;
                if (first_hi < 0) first_hi = i;
            end
        end
        checks++;
        if (hi_cnt != 4 || first_hi != 2) begin
            errors++;
            $display("FAIL latch_width got %0d cycles from %0d want 4 from 2", hi_cnt, first_hi);
        end
        wait_readable(ok, cyc);
        model_frame(1'b1);
        checks++;
        if (!ok || {bus.Connected, bus.Buttons, bus.Pressed} !== {e_con, e_btn, e_prs}) begin
            errors++;
            $display("FAIL post_reset_frame ok %b got %b %h %h want %b %h %h", ok, bus.Connected, bus.Buttons,
                     bus.Pressed, e_con, e_btn, e_prs);
        end
    endtask

    initial begin
        rep[0] = 16'h0;
        rep[1] = 16'h0;
        test_reset();
        test_nes_press();
        test_snes_disconnected();
        test_snes_bit8();
        test_random();
        test_mode_switch();
        test_steady_timing();
        test_reset_mid_shift();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
